// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: launches one request per load/store, stalls the pipe
// until mem_ack, then updates MEM/WB. Optional build macro MEM_TIMEOUT_EN adds a 16-cycle REQ timeout.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ctrl_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rt_data_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_reg_w,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_mem_data,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_buf;
  logic        w_memop;
  logic        w_timeout;

  assign w_memop = ctrl_in[1] | ctrl_in[0];

`ifdef MEM_TIMEOUT_EN
  logic [3:0] r_tcnt;
  logic       r_terr;

  // r_tcnt==15 with no ack means this is the 16th REQ cycle without completion
  assign w_timeout   = (r_state == REQ) && !mem_ack && (r_tcnt == 4'hF);
  assign timeout_err = r_terr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else begin
      if (r_state == IDLE && w_memop)
        r_tcnt <= '0;
      else if (r_state == REQ && !mem_ack)
        r_tcnt <= r_tcnt + 4'd1;
      if (w_timeout)
        r_terr <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop) begin
          stall  = 1'b1;
          w_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      r_buf         <= '0;
      wb_reg_w      <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd_addr    <= '0;
      wb_alu        <= '0;
      wb_mem_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memop) begin
            // Mem_w wins when both bits are set, so the op is a write
            mem_req       <= 1'b1;
            mem_we        <= ctrl_in[1];
            mem_addr      <= {alu_in[31:2], 2'b00};
            mem_wdata     <= rt_data_in;
            wb_reg_w      <= 1'b0;
            wb_mem_to_reg <= 1'b0;
          end else begin
            wb_reg_w      <= ctrl_in[2];
            wb_mem_to_reg <= 1'b0;
            wb_rd_addr    <= rd_addr_in;
            wb_alu        <= alu_in;
          end
        end
        REQ: begin
          wb_reg_w      <= 1'b0;
          wb_mem_to_reg <= 1'b0;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) r_buf <= mem_rdata;
          end else if (w_timeout) begin
            mem_req <= 1'b0;
            r_buf   <= 32'hDEADBEEF;
          end
        end
        DONE: begin
          // ctrl_in still shows the stalled memory op; it retires here without relaunching
          wb_reg_w      <= ctrl_in[2];
          wb_mem_to_reg <= ctrl_in[0] & ~ctrl_in[1];
          wb_rd_addr    <= rd_addr_in;
          wb_alu        <= alu_in;
          wb_mem_data   <= r_buf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset/timeout sequences,
// and randomized instructions checked against a transaction-level model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ctrl_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] alu_in, rt_data_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, wb_reg_w, wb_mem_to_reg;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_alu, wb_mem_data;
  logic        timeout_err;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .rd_addr_in(rd_addr_in),
    .alu_in(alu_in), .rt_data_in(rt_data_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .wb_reg_w(wb_reg_w), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd_addr(wb_rd_addr), .wb_alu(wb_alu), .wb_mem_data(wb_mem_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  c;
    logic [4:0]  rd;
    logic [31:0] alu, rt;
    int          dly;
    logic [31:0] rdata;
    logic        junk;
    int          exp_st;
    logic [31:0] exp_addr;
    logic        exp_rw, exp_m2r;
    logic [31:0] exp_md;
  } vec_t;

  int          checks = 0, errors = 0;
  logic [31:0] last_load;
  vec_t        tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Caller must be at posedge+1. Memory acks in REQ cycle index dly (0-based).
  task automatic run_instr(input vec_t v);
    int   stalls, req_k;
    logic memop;
    memop = v.c[1] | v.c[0];
    ctrl_in = v.c; rd_addr_in = v.rd; alu_in = v.alu; rt_data_in = v.rt;
    mem_ack = v.junk; mem_rdata = $urandom;
    #1;
    stalls = 0; req_k = 0;
    while (stall === 1'b1 && stalls < 300) begin
      if (stalls == 0) chk("idle_req", {31'd0, mem_req}, 32'd0);
      else begin
        chk("req_hold", {31'd0, mem_req}, 32'd1);
        chk("req_we", {31'd0, mem_we}, {31'd0, v.c[1]});
        chk("req_addr", mem_addr, v.exp_addr);
        chk("req_wdata", mem_wdata, v.rt);
        mem_ack   = (req_k == v.dly);
        mem_rdata = (req_k == v.dly) ? v.rdata : $urandom;
        req_k++;
      end
      stalls++;
      cyc();
      mem_ack = 1'b0;
      chk("bubble", {30'd0, wb_reg_w, wb_mem_to_reg}, 32'd0);
    end
    chk("stall_cycles", 32'(stalls), 32'(v.exp_st));
    if (memop) begin
      chk("done_req", {31'd0, mem_req}, 32'd0);
      mem_ack = v.junk; mem_rdata = $urandom;
    end
    cyc();
    mem_ack = 1'b0;
    chk("wb_reg_w", {31'd0, wb_reg_w}, {31'd0, v.exp_rw});
    chk("wb_m2r", {31'd0, wb_mem_to_reg}, {31'd0, v.exp_m2r});
    chk("wb_rd", {27'd0, wb_rd_addr}, {27'd0, v.rd});
    chk("wb_alu", wb_alu, v.alu);
    chk("wb_mdata", wb_mem_data, v.exp_md);
  endtask

  // Transaction-level expectation from the instruction and the memory response
  function automatic vec_t model(input logic [2:0] c, input logic [4:0] rd,
                                 input logic [31:0] alu, rt, input int dly,
                                 input logic [31:0] rdata, input logic junk);
    vec_t v;
    logic memop, is_load;
    memop   = c[1] | c[0];
    is_load = c[0] & ~c[1];
    if (is_load) last_load = rdata;
    v.c = c; v.rd = rd; v.alu = alu; v.rt = rt; v.dly = dly; v.rdata = rdata; v.junk = junk;
    v.exp_st   = memop ? dly + 2 : 0;
    v.exp_addr = alu & 32'hFFFF_FFFC;
    v.exp_rw   = c[2];
    v.exp_m2r  = is_load;
    v.exp_md   = last_load;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; #2;
    rst_n = 1'b1; last_load = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    rst_n = 1'b0; ctrl_in = '0; rd_addr_in = '0; alu_in = '0; rt_data_in = '0;
    mem_ack = 1'b0; mem_rdata = '0; last_load = '0;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wb", {27'd0, wb_reg_w, wb_mem_to_reg, wb_rd_addr[2:0]}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd_addr}, 32'd0);
    chk("rst_wb_alu", wb_alu, 32'd0);
    chk("rst_wb_md", wb_mem_data, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;

    //        c       rd     alu            rt             dly rdata          junk st addr           rw    m2r   md
    tbl[0] = '{3'b100, 5'd5,  32'h55,       32'h0,         0, 32'h0,         1'b1, 0, 32'h54,       1'b1, 1'b0, 32'h0};
    tbl[1] = '{3'b101, 5'd2,  32'h1003,     32'h0,         1, 32'hCAFE0001,  1'b1, 3, 32'h1000,     1'b1, 1'b1, 32'hCAFE0001};
    tbl[2] = '{3'b010, 5'd7,  32'h2000,     32'hA5A5A5A5,  0, 32'h0,         1'b0, 2, 32'h2000,     1'b0, 1'b0, 32'hCAFE0001};
    tbl[3] = '{3'b011, 5'd3,  32'h300A,     32'h1234,      3, 32'h0BAD,      1'b1, 5, 32'h3008,     1'b0, 1'b0, 32'hCAFE0001};
    tbl[4] = '{3'b101, 5'd31, 32'hFFFFFFFF, 32'h0,         0, 32'h11223344,  1'b0, 2, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h11223344};
    tbl[5] = '{3'b000, 5'd9,  32'h0,        32'h0,         0, 32'h0,         1'b1, 0, 32'h0,        1'b0, 1'b0, 32'h11223344};
    foreach (tbl[i]) run_instr(tbl[i]);
    last_load = 32'h11223344;

    // Reset in the middle of REQ abandons the access; a late ack is ignored
    ctrl_in = 3'b101; rd_addr_in = 5'd4; alu_in = 32'h4000; rt_data_in = '0;
    cyc();
    chk("mid_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_wb_alu", wb_alu, 32'd0);
    chk("arst_wb_md", wb_mem_data, 32'd0);
    ctrl_in = '0; rd_addr_in = '0; alu_in = '0;
    rst_n = 1'b1; last_load = '0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    cyc();
    mem_ack = 1'b0;
    chk("late_ack_wb", {27'd0, wb_reg_w, wb_mem_to_reg, 3'd0} | {27'd0, wb_rd_addr}, 32'd0);
    chk("late_ack_md", wb_mem_data, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    v = model(3'b100, 5'd12, 32'h777, 32'h0, 0, 32'h0, 1'b0);
    run_instr(v);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      v = model(3'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom,
                $urandom_range(0, 4), $urandom, 1'($urandom));
      run_instr(v);
    end

    // Load that is never acknowledged
    ctrl_in = 3'b101; rd_addr_in = 5'd6; alu_in = 32'h5000; mem_ack = 1'b0;
    #1;
    n = 0;
`ifdef MEM_TIMEOUT_EN
    while (stall === 1'b1 && n < 100) begin n++; cyc(); end
    chk("to_stalls", 32'(n), 32'd17);
    chk("to_terr", {31'd0, timeout_err}, 32'd1);
    cyc();
    chk("to_md", wb_mem_data, 32'hDEADBEEF);
    chk("to_m2r", {31'd0, wb_mem_to_reg}, 32'd1);
    ctrl_in = 3'b100;
    cyc(); cyc();
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    do_reset();
    #1;
    chk("to_cleared", {31'd0, timeout_err}, 32'd0);
`else
    while (stall === 1'b1 && n < 100) begin n++; cyc(); end
    chk("hold_stalls", 32'(n), 32'd100);
    chk("hold_terr", {31'd0, timeout_err}, 32'd0);
    chk("hold_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h600D600D;
    cyc();
    mem_ack = 1'b0;
    chk("hold_done", {31'd0, stall}, 32'd0);
    cyc();
    chk("hold_md", wb_mem_data, 32'h600D600D);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low: clk and rst_n.
REQ-002 Port list SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- ctrl_in  in  3  EX/MEM control: [2]=Reg_w, [1]=Mem_w, [0]=Mem_r
- rd_addr_in  in  5  EX/MEM destination register
- alu_in  in  32  EX/MEM ALU result / memory address
- rt_data_in  in  32  EX/MEM store data
- mem_req  out  1  data-memory request, registered
- mem_we  out  1  1=write, 0=read, valid with mem_req
- mem_addr  out  32  word address, {alu_in[31:2],2'b00}, registered
- mem_wdata  out  32  store data, registered
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  32  read data, valid with mem_ack
- stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM
- wb_reg_w  out  1  MEM/WB register-write enable
- wb_mem_to_reg  out  1  MEM/WB select: 1=wb_mem_data, 0=wb_alu
- wb_rd_addr  out  5  MEM/WB destination register
- wb_alu  out  32  MEM/WB ALU result
- wb_mem_data  out  32  MEM/WB load data
- timeout_err  out  1  sticky memory-timeout flag

Function
REQ-003 States SHALL be IDLE, REQ, DONE.
REQ-004 IDLE, ctrl_in[1]|ctrl_in[0]=1: stall=1; next edge -> REQ; mem_req<=1; mem_we<=ctrl_in[1]; mem_addr and mem_wdata latched.
REQ-005 IDLE, no memory op: stall=0; MEM/WB loads at the next edge (1-cycle latency), wb_mem_to_reg<=0.
REQ-006 REQ: stall=1; mem_req, mem_we, mem_addr and mem_wdata held stable until mem_ack is sampled 1.
REQ-007 REQ with mem_ack=1: next edge -> DONE; mem_req<=0; mem_rdata captured in an internal buffer (reads only).
REQ-008 DONE: stall=0; next edge loads MEM/WB from ctrl_in and rd_addr_in, wb_mem_data<=buffer, wb_mem_to_reg<=Mem_r & ~Mem_w; -> IDLE unconditionally.
REQ-009 DONE SHALL NOT re-launch an access, even though ctrl_in still shows a memory op.
REQ-010 Minimum memory-op occupancy SHALL be 3 cycles (IDLE, REQ, DONE) when mem_ack arrives in the first REQ cycle.
REQ-011 On every edge where stall=1, MEM/WB SHALL load a bubble: wb_reg_w<=0, wb_mem_to_reg<=0; other wb_* fields hold.
REQ-012 Mem_w=Mem_r=1 SHALL be treated as a write: mem_we=1, wb_mem_to_reg=0.
REQ-013 mem_ack in IDLE or DONE SHALL be ignored.
REQ-014 alu_in[1:0] SHALL be discarded; there is no misalignment detection.
REQ-015 Store data SHALL pass unmodified; wb_alu<=alu_in for every instruction.

Reset
REQ-016 rst_n=0 SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all wb_* outputs=0, internal buffer=0, timeout_err=0.
REQ-017 Reset during REQ SHALL abandon the access with no MEM/WB update; a late mem_ack after reset SHALL be ignored.
REQ-018 After rst_n deasserts, stall SHALL follow REQ-004 from the first edge.

Configuration
REQ-019 Macro MEM_TIMEOUT_EN, when defined, SHALL add a 4-bit counter that is cleared on entry to REQ and increments each REQ cycle without mem_ack.
REQ-020 With MEM_TIMEOUT_EN defined, a 16th consecutive REQ cycle without mem_ack SHALL force the transition to DONE, buffer<=32'hDEADBEEF, mem_req<=0 and timeout_err<=1, sticky until reset.
REQ-021 Without MEM_TIMEOUT_EN, REQ SHALL wait indefinitely, and timeout_err SHALL be tied to 0.

Verification
REQ-022 ctrl_in=3'b100, alu_in=32'h55, rd=5 -> stall=0; next edge wb_reg_w=1, wb_rd_addr=5, wb_alu=32'h55, wb_mem_to_reg=0.
REQ-023 Load, ctrl_in=3'b101, alu_in=32'h1003, mem_ack after 2 REQ cycles with rdata=32'hCAFE0001 -> mem_addr=32'h1000, mem_we=0, stall=1 for 3 cycles, then wb_mem_data=32'hCAFE0001, wb_mem_to_reg=1, wb_reg_w=1.
REQ-024 Store, ctrl_in=3'b010, rt_data_in=32'hA5A5A5A5 -> mem_we=1, mem_wdata=32'hA5A5A5A5; wb_reg_w=0 throughout; returns to IDLE after DONE.
REQ-025 rst_n pulsed low during REQ -> mem_req=0 at once; a following mem_ack causes no wb_* change; the next ALU op completes normally.
REQ-026 MEM_TIMEOUT_EN defined, load with no mem_ack -> exactly 16 REQ cycles, then wb_mem_data=32'hDEADBEEF and timeout_err=1 until reset; MEM_TIMEOUT_EN undefined -> stall held for 100 cycles and timeout_err=0.
